// File: rtl/draw_over_anim_if.sv
// VGA timing plus pixel colour bundle passed between draw stages.
// vga_in is the receiving side of a stage, vga_out the driving side.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_over_anim.sv
// Animated end-of-game overlay: a bordered box slides down to its rest row,
// then holds with a blinking border. One cycle of latency on every VGA field.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | overlay hidden, waiting for the trigger code at a frame tick
// S_SLIDE | box top moves down SLIDE_STEP per frame until Y_REST
// S_HOLD  | box parked at Y_REST, border toggles every BLINK_FRAMES frames
module draw_over_anim #(
  parameter logic [2:0]  TRIGGER_STATE = 3'b100,
  parameter int          X_START       = 400,
  parameter int          BOX_W         = 200,
  parameter int          Y_REST        = 200,
  parameter int          BOX_H         = 100,
  parameter int          SLIDE_STEP    = 8,
  parameter int          BORDER_W      = 4,
  parameter int          BLINK_FRAMES  = 30,
  parameter logic [11:0] FILL_COLOR    = 12'hFF0,
  parameter logic [11:0] BORDER_COLOR  = 12'hF00
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   game_state,
  vga_if.vga_in        vga_in,
  vga_if.vga_out       vga_out,
  output logic         overlay_active,
  output logic         slide_done
);

  typedef enum logic [1:0] {S_IDLE, S_SLIDE, S_HOLD} state_t;

  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [11:0] X_LO   = 12'(X_START);
  localparam logic [11:0] X_HI   = 12'(X_START + BOX_W);
  localparam logic [11:0] BW12   = 12'(BORDER_W);
  localparam logic [11:0] H12    = 12'(BOX_H);
  localparam logic [11:0] STEP12 = 12'(SLIDE_STEP);
  localparam logic [11:0] REST12 = 12'(Y_REST);
  localparam logic [10:0] REST11 = 11'(Y_REST);

  state_t               state_q, state_d;
  logic [10:0]          y_pos_q, y_pos_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 border_on_q, border_on_d;
  logic                 vblnk_dly_q, vblnk_dly_d;
  logic                 overlay_active_q, overlay_active_d;
  logic                 slide_done_q, slide_done_d;

  logic [10:0]          hcount_q, hcount_d;
  logic [10:0]          vcount_q, vcount_d;
  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;
  logic                 hblnk_q, hblnk_d;
  logic                 vblnk_q, vblnk_d;
  logic [11:0]          rgb_q, rgb_d;

  logic                 tick;
  logic                 trig;
  logic [11:0]          y_sum;
  logic [10:0]          y_step;
  logic [11:0]          h12, v12, y_top, y_bot;
  logic                 in_box, on_border;

  always_comb begin
    state_d          = state_q;
    y_pos_d          = y_pos_q;
    blink_cnt_d      = blink_cnt_q;
    border_on_d      = border_on_q;
    slide_done_d     = 1'b0;
    vblnk_dly_d      = vga_in.vblnk;
    tick             = vga_in.vblnk & ~vblnk_dly_q;
    trig             = (game_state == TRIGGER_STATE);
    // 12-bit sum so the saturating step can never wrap
    y_sum            = {1'b0, y_pos_q} + STEP12;
    y_step           = (y_sum >= REST12) ? REST11 : y_sum[10:0];

    if (tick) begin
      if (state_q != S_IDLE && !trig) begin
        state_d     = S_IDLE;
        y_pos_d     = '0;
        blink_cnt_d = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (trig) begin
              state_d     = S_SLIDE;
              y_pos_d     = '0;
              blink_cnt_d = '0;
              border_on_d = 1'b1;
            end
          end
          S_SLIDE: begin
            y_pos_d = y_step;
            if (y_step == REST11) begin
              state_d      = S_HOLD;
              slide_done_d = 1'b1;
            end
          end
          S_HOLD: begin
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              border_on_d = ~border_on_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    overlay_active_d = (state_d != S_IDLE);
  end

  always_comb begin
    hcount_d  = vga_in.hcount;
    vcount_d  = vga_in.vcount;
    hsync_d   = vga_in.hsync;
    vsync_d   = vga_in.vsync;
    hblnk_d   = vga_in.hblnk;
    vblnk_d   = vga_in.vblnk;
    h12       = {1'b0, vga_in.hcount};
    v12       = {1'b0, vga_in.vcount};
    y_top     = {1'b0, y_pos_q};
    y_bot     = y_top + H12;
    in_box    = (h12 >= X_LO) && (h12 < X_HI) && (v12 >= y_top) && (v12 < y_bot);
    // far-edge tests add to the pixel side so a narrow box cannot underflow
    on_border = (h12 < X_LO + BW12) || (h12 + BW12 >= X_HI) ||
                (v12 < y_top + BW12) || (v12 + BW12 >= y_bot);
    rgb_d     = vga_in.rgb;
    if (state_q != S_IDLE && !vga_in.hblnk && !vga_in.vblnk && in_box) begin
      rgb_d = (on_border && border_on_q) ? BORDER_COLOR : FILL_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      y_pos_q          <= '0;
      blink_cnt_q      <= '0;
      border_on_q      <= 1'b1;
      vblnk_dly_q      <= 1'b0;
      overlay_active_q <= 1'b0;
      slide_done_q     <= 1'b0;
      hcount_q         <= '0;
      vcount_q         <= '0;
      hsync_q          <= 1'b0;
      vsync_q          <= 1'b0;
      hblnk_q          <= 1'b0;
      vblnk_q          <= 1'b0;
      rgb_q            <= '0;
    end else begin
      state_q          <= state_d;
      y_pos_q          <= y_pos_d;
      blink_cnt_q      <= blink_cnt_d;
      border_on_q      <= border_on_d;
      vblnk_dly_q      <= vblnk_dly_d;
      overlay_active_q <= overlay_active_d;
      slide_done_q     <= slide_done_d;
      hcount_q         <= hcount_d;
      vcount_q         <= vcount_d;
      hsync_q          <= hsync_d;
      vsync_q          <= vsync_d;
      hblnk_q          <= hblnk_d;
      vblnk_q          <= vblnk_d;
      rgb_q            <= rgb_d;
    end
  end

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = rgb_q;
  assign overlay_active = overlay_active_q;
  assign slide_done     = slide_done_q;

endmodule

// File: tb/tb_draw_over_anim.sv
// Bench for draw_over_anim: sparse synthetic frames, a one-deep scoreboard
// fed by a behavioural model, plus directed pixel checks against constants.
module tb_draw_over_anim;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] game_state = 3'b000;
  logic       overlay_active;
  logic       slide_done;

  vga_if vin ();
  vga_if vout ();

  draw_over_anim dut (
    .clk            (clk),
    .rst            (rst),
    .game_state     (game_state),
    .vga_in         (vin),
    .vga_out        (vout),
    .overlay_active (overlay_active),
    .slide_done     (slide_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [25:0] tim;
    logic [11:0] rgb;
    logic        act;
    logic        done;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          frame_no = 0;
  int          done_cnt = 0;
  int          done_frame = -1;
  logic [11:0] last_rgb;

  int m_state = 0, m_y = 0, m_blink = 0;
  bit m_border = 1, m_vd = 0, m_active = 0, m_done = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s frame=%0d got=%h want=%h", tag, frame_no, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(input int h, input int v, input logic hb,
                                            input logic vb, input logic [11:0] rin);
    int top, bot;
    bit inb, brd;
    top = m_y;
    bot = m_y + 100;
    inb = (h >= 400) && (h < 600) && (v >= top) && (v < bot);
    brd = (h < 404) || (h >= 596) || (v < top + 4) || (v >= bot - 4);
    if (m_state == 0 || hb || vb || !inb) return rin;
    return (brd && m_border) ? 12'hF00 : 12'hFF0;
  endfunction

  task automatic model_step(input logic vb);
    bit tk, trig;
    m_done = 0;
    if (rst) begin
      m_state = 0; m_y = 0; m_blink = 0; m_border = 1; m_vd = 0; m_active = 0;
      return;
    end
    tk   = vb && !m_vd;
    m_vd = vb;
    trig = (game_state == 3'b100);
    if (tk) begin
      if (m_state != 0 && !trig) begin
        m_state = 0; m_y = 0; m_blink = 0;
      end else if (m_state == 0) begin
        if (trig) begin m_state = 1; m_y = 0; m_blink = 0; m_border = 1; end
      end else if (m_state == 1) begin
        m_y = (m_y + 8 > 200) ? 200 : m_y + 8;
        if (m_y == 200) begin m_state = 2; m_done = 1; end
      end else begin
        if (m_blink == 29) begin m_blink = 0; m_border = !m_border; end
        else m_blink++;
      end
    end
    m_active = (m_state != 0);
  endtask

  task automatic cyc(input logic [10:0] h, input logic [10:0] v, input logic hs, input logic vs,
                     input logic hb, input logic vb, input logic [11:0] rgb);
    exp_t e, g;
    @(negedge clk);
    vin.hcount = h; vin.vcount = v; vin.hsync = hs; vin.vsync = vs;
    vin.hblnk = hb; vin.vblnk = vb; vin.rgb = rgb;
    if (rst) e = '0;
    else begin
      e.tim = {h, v, hs, vs, hb, vb};
      e.rgb = model_rgb(int'(h), int'(v), hb, vb, rgb);
    end
    model_step(vb);
    e.act  = m_active;
    e.done = m_done;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    last_rgb = vout.rgb;
    if (slide_done) begin done_cnt++; done_frame = frame_no; end
    check_eq("timing", {6'd0, vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}, {6'd0, g.tim});
    check_eq("rgb", {20'd0, vout.rgb}, {20'd0, g.rgb});
    check_eq("active", {31'd0, overlay_active}, {31'd0, g.act});
    check_eq("slide_done", {31'd0, slide_done}, {31'd0, g.done});
  endtask

  task automatic pix(input int h, input int v, input logic [11:0] rgb, input logic hb = 1'b0);
    logic [10:0] hh, vv;
    hh = 11'(h);
    vv = 11'(v);
    cyc(hh, vv, hh[0], vv[0], hb, 1'b0, rgb);
  endtask

  task automatic tick();
    cyc(11'd0, 11'd600, 1'b0, 1'b1, 1'b1, 1'b1, 12'h123);
    cyc(11'd0, 11'd601, 1'b0, 1'b0, 1'b1, 1'b0, 12'h321);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int y;
    logic [11:0] ph;
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;

    // reset then ramp pass-through
    rst = 1'b1;
    for (int i = 0; i < 2; i++) cyc(11'(i + 5), 11'(i + 7), 1'b1, 1'b1, 1'b1, 1'b1, 12'hABC);
    check_eq("reset_rgb", {20'd0, last_rgb}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++)
      cyc(11'(i * 37), 11'(i * 13), i[0], i[1], i[2], i[3], 12'(i * 211));

    // slide profile
    game_state = 3'b100;
    tick();
    for (int k = 1; k <= 30; k++) begin
      frame_no = k;
      tick();
      y = (8 * k > 200) ? 200 : 8 * k;
      pix(500, y - 1, 12'h05A);
      check_eq("above_box", {20'd0, last_rgb}, 32'h05A);
      pix(500, y, 12'h05A);
      check_eq("top_border", {20'd0, last_rgb}, 32'hF00);
      pix(500, y + 4, 12'h05A);
      check_eq("interior", {20'd0, last_rgb}, 32'hFF0);
      pix(400, 200, 12'h0C3);
    end
    check_eq("done_cnt", done_cnt, 1);
    check_eq("done_frame", done_frame, 25);

    // blink in HOLD
    for (int k = 31; k <= 150; k++) begin
      frame_no = k;
      tick();
      ph = (((k - 25) / 30) % 2 == 0) ? 12'hF00 : 12'hFF0;
      pix(401, 250, 12'h111);
      check_eq("blink_border", {20'd0, last_rgb}, {20'd0, ph});
      pix(500, 250, 12'h111);
      check_eq("blink_fill", {20'd0, last_rgb}, 32'hFF0);
    end

    // edges and blanking (frame 150: phase 4 => border on)
    pix(599, 299, 12'h222);
    check_eq("edge_599_299", {20'd0, last_rgb}, 32'hF00);
    pix(600, 299, 12'h222);
    check_eq("edge_600", {20'd0, last_rgb}, 32'h222);
    pix(599, 300, 12'h223);
    check_eq("edge_300", {20'd0, last_rgb}, 32'h223);
    pix(500, 250, 12'h224, 1'b1);
    check_eq("hblnk_pass", {20'd0, last_rgb}, 32'h224);
    game_state = 3'b000;
    pix(500, 250, 12'h225);
    check_eq("between_ticks", {20'd0, last_rgb}, 32'hFF0);
    game_state = 3'b100;

    // abort mid-slide, then restart
    game_state = 3'b001;
    tick();
    game_state = 3'b100;
    tick();
    for (int k = 1; k <= 10; k++) begin
      frame_no = 200 + k;
      if (k == 10) game_state = 3'b001;
      tick();
      pix(500, 72, 12'h333);
    end
    check_eq("abort_active", {31'd0, overlay_active}, 32'd0);
    check_eq("abort_absent", {20'd0, last_rgb}, 32'h333);
    game_state = 3'b100;
    tick();
    pix(500, 0, 12'h334);
    check_eq("restart_y0", {20'd0, last_rgb}, 32'hF00);
    pix(500, 100, 12'h335);
    check_eq("restart_bot", {20'd0, last_rgb}, 32'h335);
    tick();
    pix(500, 8, 12'h336);
    check_eq("restart_y8", {20'd0, last_rgb}, 32'hF00);
    pix(500, 7, 12'h337);
    check_eq("restart_above", {20'd0, last_rgb}, 32'h337);

    // reach HOLD again then reset mid-HOLD
    for (int k = 2; k <= 26; k++) begin
      frame_no = 300 + k;
      tick();
      pix(450, 260, 12'h444);
    end
    check_eq("hold_active", {31'd0, overlay_active}, 32'd1);
    rst = 1'b1;
    pix(500, 250, 12'h555);
    check_eq("rst_rgb", {20'd0, last_rgb}, 32'd0);
    check_eq("rst_active", {31'd0, overlay_active}, 32'd0);
    rst = 1'b0;
    pix(500, 250, 12'h556);
    check_eq("post_rst_pass", {20'd0, last_rgb}, 32'h556);
    tick();
    pix(500, 0, 12'h557);
    check_eq("post_rst_slide", {20'd0, last_rgb}, 32'hF00);
    pix(500, 250, 12'h558);
    check_eq("post_rst_below", {20'd0, last_rgb}, 32'h558);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
